// File: rtl/uart_rx_frame_parser_if.sv
// rtl/uart_rx_frame_parser_if.sv - byte input and held-frame read bundle for uart_rx_frame_parser
interface uart_rx_frame_parser_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned LEN_WIDTH = 5
);
  logic [WORD_SIZE-1:0] rx_data;
  logic                 rx_data_ready;
  logic                 frame_valid;
  logic [WORD_SIZE-1:0] frame_cmd;
  logic [LEN_WIDTH-1:0] frame_len;
  logic [LEN_WIDTH-1:0] rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 frame_ack;

  // Parser side
  modport slave (
    input  rx_data, rx_data_ready, rd_addr, frame_ack,
    output frame_valid, frame_cmd, frame_len, rd_data
  );

  // Receiver / host side
  modport master (
    output rx_data, rx_data_ready, rd_addr, frame_ack,
    input  frame_valid, frame_cmd, frame_len, rd_data
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - SYNC/CMD/LEN/payload/CHK frame parser; UART_FRAME_TIMEOUT_EN adds an inter-byte timeout
module uart_rx_frame_parser #(
  parameter int unsigned          WORD_SIZE      = 8,
  parameter int unsigned          MAX_LEN        = 16,
  parameter int unsigned          LEN_WIDTH      = 5,
  parameter logic [WORD_SIZE-1:0] SYNC_BYTE      = 8'hA5,
  parameter int unsigned          TIMEOUT_CYCLES = 1000000,
  parameter int unsigned          TIMEOUT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset_b,
  uart_rx_frame_parser_if.slave bus,
  output logic                  err_len,
  output logic                  err_chk,
  output logic                  err_timeout,
  output logic [7:0]            drop_cnt
);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN >= (1 << LEN_WIDTH)) begin : g_len_width_chk
    $error("LEN_WIDTH cannot hold MAX_LEN");
  end
  if (TIMEOUT_CYCLES > (1 << TIMEOUT_WIDTH)) begin : g_to_width_chk
    $error("TIMEOUT_WIDTH cannot hold TIMEOUT_CYCLES");
  end

  logic [2:0]           state_q, state_d;
  logic                 ready_q;
  logic [WORD_SIZE-1:0] chk_q, chk_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [WORD_SIZE-1:0] cmd_q, cmd_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [WORD_SIZE-1:0] frame_cmd_q, frame_cmd_d;
  logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
  logic                 err_len_q, err_len_d;
  logic                 err_chk_q, err_chk_d;
  logic [7:0]           drop_q, drop_d;
  logic                 buf_we;
  logic [WORD_SIZE-1:0] pbuf_q [MAX_LEN];
  logic                 byte_stb;
  logic                 to_hit;

  // A level held for many cycles still yields one byte: only its rising edge counts
  assign byte_stb = bus.rx_data_ready & ~ready_q;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q;
  logic                     err_to_q;
  logic                     in_frame;

  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign to_hit   = in_frame && !byte_stb &&
                    (to_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Idle-gap counter: restarts on each byte, parked at zero outside a frame
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= to_hit;
      if (byte_stb || !in_frame || to_hit) to_cnt_q <= '0;
      else                                 to_cnt_q <= to_cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  assign err_timeout = err_to_q;
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Frame FSM: one transition per byte strobe; the held frame is only released by an ack
  always_comb begin
    state_d       = state_q;
    chk_d         = chk_q;
    idx_d         = idx_q;
    len_d         = len_q;
    cmd_d         = cmd_q;
    frame_valid_d = frame_valid_q;
    frame_cmd_d   = frame_cmd_q;
    frame_len_d   = frame_len_q;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    drop_d        = drop_q;
    buf_we        = 1'b0;
    if (to_hit) begin
      state_d = S_HUNT;
    end else begin
      case (state_q)
        S_HUNT: begin
          if (byte_stb && bus.rx_data == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          if (byte_stb) begin
            cmd_d   = bus.rx_data;
            chk_d   = bus.rx_data;
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (byte_stb) begin
            if (bus.rx_data > WORD_SIZE'(MAX_LEN)) begin
              err_len_d = 1'b1;
              state_d   = S_HUNT;
            end else begin
              chk_d   = chk_q ^ bus.rx_data;
              len_d   = bus.rx_data[LEN_WIDTH-1:0];
              idx_d   = '0;
              state_d = (bus.rx_data == '0) ? S_CHK : S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_stb) begin
            buf_we = 1'b1;
            chk_d  = chk_q ^ bus.rx_data;
            idx_d  = idx_q + LEN_WIDTH'(1);
            if (idx_q == len_q - LEN_WIDTH'(1)) state_d = S_CHK;
          end
        end
        S_CHK: begin
          if (byte_stb) begin
            if (bus.rx_data == chk_q) begin
              frame_valid_d = 1'b1;
              frame_cmd_d   = cmd_q;
              frame_len_d   = len_q;
              state_d       = S_HOLD;
            end else begin
              err_chk_d = 1'b1;
              state_d   = S_HUNT;
            end
          end
        end
        S_HOLD: begin
          if (byte_stb && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          if (bus.frame_ack) begin
            frame_valid_d = 1'b0;
            state_d       = S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= S_HUNT;
      ready_q       <= 1'b0;
      chk_q         <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      cmd_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_cmd_q   <= '0;
      frame_len_q   <= '0;
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= bus.rx_data_ready;
      chk_q         <= chk_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      cmd_q         <= cmd_d;
      frame_valid_q <= frame_valid_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_len_q   <= frame_len_d;
      err_len_q     <= err_len_d;
      err_chk_q     <= err_chk_d;
      drop_q        <= drop_d;
    end
  end

  // Payload store; contents survive reset and are only meaningful while a frame is held
  always_ff @(posedge clk) begin
    if (buf_we && idx_q < LEN_WIDTH'(MAX_LEN)) pbuf_q[idx_q[AW-1:0]] <= bus.rx_data;
  end

  assign bus.rd_data     = (bus.rd_addr < LEN_WIDTH'(MAX_LEN)) ? pbuf_q[bus.rd_addr[AW-1:0]] : '0;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_cmd   = frame_cmd_q;
  assign bus.frame_len   = frame_len_q;
  assign err_len         = err_len_q;
  assign err_chk         = err_chk_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - scoreboard bench for uart_rx_frame_parser
module tb_uart_rx_frame_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXL = 16;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TB_TO = 50;
`else
  localparam int TB_TO = 1000000;
`endif
  localparam int EV_FRAME = 1;
  localparam int EV_LEN   = 2;
  localparam int EV_CHK   = 3;
  localparam int EV_TO    = 4;

  typedef struct {
    int kind;
    int cyc;
    int cmd;
    int len;
    int pl[16];
  } ev_t;

  logic       clk;
  logic       reset_b;
  logic       err_len, err_chk, err_timeout;
  logic [7:0] drop_cnt;

  uart_rx_frame_parser_if bus ();

  uart_rx_frame_parser #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .bus        (bus),
    .err_len    (err_len),
    .err_chk    (err_chk),
    .err_timeout(err_timeout),
    .drop_cnt   (drop_cnt)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int frames_seen = 0;
  int frames_done = 0;

  ev_t        exp_q[$];
  logic [7:0] fb[$];
  logic [7:0] sq[$];
  bit         m_hold = 0;
  int         m_drop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: buffers a candidate frame as a byte list and judges it once complete
  task automatic model_byte(input logic [7:0] b, input int c);
    ev_t e;
    int  x;
    e.kind = 0; e.cyc = c; e.cmd = 0; e.len = 0;
    for (int i = 0; i < 16; i++) e.pl[i] = 0;
    if (m_hold) begin
      if (m_drop < 255) m_drop++;
      return;
    end
    if (fb.size() == 0) begin
      if (b == SYNC) fb.push_back(b);
      return;
    end
    fb.push_back(b);
    if (fb.size() == 3 && int'(fb[2]) > MAXL) begin
      e.kind = EV_LEN;
      exp_q.push_back(e);
      fb.delete();
      return;
    end
    if (fb.size() >= 3 && fb.size() == int'(fb[2]) + 4) begin
      x = 0;
      for (int i = 1; i < fb.size() - 1; i++) x = x ^ int'(fb[i]);
      e.cmd = int'(fb[1]);
      e.len = int'(fb[2]);
      if (x == int'(fb[fb.size()-1])) begin
        e.kind = EV_FRAME;
        for (int i = 0; i < e.len; i++) e.pl[i] = int'(fb[3+i]);
        m_hold = 1;
      end else begin
        e.kind = EV_CHK;
      end
      exp_q.push_back(e);
      fb.delete();
    end
  endtask

  task automatic model_reset();
    fb.delete();
    exp_q.delete();
    m_hold = 0;
    m_drop = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(posedge clk);
    #1;
    bus.rx_data       = b;
    bus.rx_data_ready = 1'b1;
    model_byte(b, cyc);
    repeat (hi) @(posedge clk);
    #1;
    bus.rx_data_ready = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic service_hold(input int k, input bit wb);
    int         t;
    logic [7:0] b;
    t = 0;
    while (frames_seen == frames_done && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("hold_frame_seen", frames_seen > frames_done, 1);
    frames_done = frames_seen;
    for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)), 1, 0);
    @(negedge clk);
    check("drop_cnt_hold", drop_cnt, m_drop);
    check("valid_in_hold", bus.frame_valid, 1);
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b1;
    if (wb) begin
      b = 8'($urandom_range(0, 255));
      bus.rx_data       = b;
      bus.rx_data_ready = 1'b1;
      model_byte(b, cyc);
    end
    @(posedge clk);
    #1;
    bus.frame_ack     = 1'b0;
    bus.rx_data_ready = 1'b0;
    m_hold = 0;
    @(negedge clk);
    check("valid_after_ack", bus.frame_valid, 0);
    check("drop_cnt_ack", drop_cnt, m_drop);
  endtask

  // hi < 0 picks random high/low times; k < 0 picks random drop count and ack-with-byte
  task automatic send_stream(input int hi, input int k, input bit wb);
    int h, l;
    for (int i = 0; i < sq.size(); i++) begin
      h = (hi < 0) ? $urandom_range(1, 4) : hi;
      l = (hi < 0) ? $urandom_range(0, 2) : 0;
      send_byte(sq[i], h, l);
      if (m_hold) begin
        if (k < 0) service_hold($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        else       service_hold(k, wb);
      end
    end
  endtask

  task automatic build_frame(input int cmd, input int len, input bit bad);
    int x;
    sq.delete();
    sq.push_back(SYNC);
    sq.push_back(8'(cmd));
    sq.push_back(8'(len));
    x = cmd ^ len;
    for (int i = 0; i < len; i++) begin
      sq.push_back(8'($urandom_range(0, 255)));
      x = x ^ int'(sq[sq.size()-1]);
    end
    if (bad) x = x ^ (1 << $urandom_range(0, 7));
    sq.push_back(8'(x));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.frame_valid, 0);
    check({tag, "_cmd"}, bus.frame_cmd, 0);
    check({tag, "_len"}, bus.frame_len, 0);
    check({tag, "_err_len"}, err_len, 0);
    check({tag, "_err_chk"}, err_chk, 0);
    check({tag, "_err_to"}, err_timeout, 0);
    check({tag, "_drop"}, drop_cnt, 0);
  endtask

  // Monitor: compares every output event against the head of the scoreboard queue
  task automatic handle_event(input int kind);
    ev_t e;
    check("event_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind != EV_TO) check("event_latency", cyc - e.cyc, 1);
      if (kind == EV_FRAME && e.kind == EV_FRAME) begin
        check("frame_cmd", bus.frame_cmd, e.cmd);
        check("frame_len", bus.frame_len, e.len);
        for (int i = 0; i < e.len; i++) begin
          bus.rd_addr = 5'(i);
          #1;
          check("rd_data", bus.rd_data, e.pl[i]);
        end
        bus.rd_addr = 5'd16;
        #1;
        check("rd_data_oob16", bus.rd_data, 0);
        bus.rd_addr = 5'd31;
        #1;
        check("rd_data_oob31", bus.rd_data, 0);
        bus.rd_addr = 5'd0;
      end
    end
    if (kind == EV_FRAME) frames_seen++;
  endtask

  initial begin
    bit fv_prev, el_prev, ec_prev, et_prev;
    fv_prev = 0; el_prev = 0; ec_prev = 0; et_prev = 0;
    bus.rd_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        fv_prev = 0; el_prev = 0; ec_prev = 0; et_prev = 0;
      end else begin
        if (err_len) begin
          check("err_len_width", {el_prev, err_len}, 2'b01);
          handle_event(EV_LEN);
        end
        if (err_chk) begin
          check("err_chk_width", {ec_prev, err_chk}, 2'b01);
          handle_event(EV_CHK);
        end
        if (err_timeout) begin
          check("err_to_width", {et_prev, err_timeout}, 2'b01);
          handle_event(EV_TO);
        end
        if (bus.frame_valid && !fv_prev) handle_event(EV_FRAME);
        el_prev = err_len;
        ec_prev = err_chk;
        et_prev = err_timeout;
        fv_prev = bus.frame_valid;
      end
    end
  end

  initial begin
    int r;
    reset_b           = 1'b0;
    bus.rx_data       = '0;
    bus.rx_data_ready = 1'b0;
    bus.frame_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_b = 1'b1;

    // Good frame, then bad checksum, then the good frame again
    sq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_stream(1, 0, 0);
    sq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hFF};
    send_stream(1, 0, 0);
    sq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_stream(2, 0, 0);

    // Oversized LEN, stray bytes, then a zero-length frame held through drops and ack+byte
    sq = '{8'hA5, 8'h07, 8'h11, 8'h00, 8'h33};
    send_stream(1, 0, 0);
    sq = '{8'hA5, 8'h05, 8'h00, 8'h05};
    send_stream(1, 3, 1);
    check("drop_cnt_four", drop_cnt, 4);

    // Reset in the middle of a payload
    sq = '{8'hA5, 8'h10, 8'h05, 8'h11, 8'h22};
    send_stream(1, 0, 0);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;

    // Long ready level: one byte per rising edge
    sq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_stream(10, 0, 0);

`ifdef UART_FRAME_TIMEOUT_EN
    send_byte(8'hA5, 1, 0);
    send_byte(8'h10, 1, 0);
    begin
      ev_t e;
      e.kind = EV_TO; e.cyc = -1; e.cmd = 0; e.len = 0;
      for (int i = 0; i < 16; i++) e.pl[i] = 0;
      exp_q.push_back(e);
      fb.delete();
    end
    repeat (60) @(posedge clk);
`endif

    // Randomized mix of frame kinds
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      build_frame($urandom_range(0, 255), $urandom_range(0, MAXL), 0);
      else if (r == 6) build_frame($urandom_range(0, 255), $urandom_range(0, MAXL), 1);
      else if (r == 7) begin
        sq = '{8'hA5, 8'h00, 8'h00};
        sq[1] = 8'($urandom_range(0, 255));
        sq[2] = 8'($urandom_range(MAXL + 1, 255));
      end else if (r == 8) begin
        sq.delete();
        for (int i = 0; i < 3; i++) sq.push_back(8'($urandom_range(0, 8'hA4)));
      end else build_frame($urandom_range(0, 255), MAXL, 0);
      send_stream(-1, -1, 0);
    end

    repeat (20) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
